// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flop computes A + B + Cin
// LSB first, one bit per clock, framed by a start/done handshake.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] sum_out,
  output logic             c_out
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             s;
  logic             carry_next;
  logic [WIDTH:0]   acc_ext;
  logic [WIDTH-1:0] acc_next;
  logic             last_bit;

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy_out   = 1'b0;
    done_out   = 1'b0;
    case (state)
      IDLE: if (start_in) state_next = RUN;
      RUN: begin
        busy_out = 1'b1;
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        done_out   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The single full-adder cell; acc_ext keeps the shift legal for WIDTH = 1.
  always_comb begin
    s          = opa[0] ^ opb[0] ^ carry;
    carry_next = (opa[0] & opb[0]) | (opa[0] & carry) | (opb[0] & carry);
    acc_ext    = {s, acc};
    acc_next   = acc_ext[WIDTH:1];
    last_bit   = (cnt == LAST);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      opa     <= '0;
      opb     <= '0;
      acc     <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
      sum_out <= '0;
      c_out   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_in) begin
            opa   <= a_in;
            opb   <= b_in;
            carry <= c_in;
            acc   <= '0;
            cnt   <= '0;
          end
        end
        RUN: begin
          opa   <= opa >> 1;
          opb   <= opb >> 1;
          carry <= carry_next;
          acc   <= acc_next;
          cnt   <= cnt + CW'(1);
          // Results publish only on the final bit so they hold between operations.
          if (last_bit) begin
            sum_out <= acc_next;
            c_out   <= carry_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: a countdown/arithmetic model predicts every
// output each cycle, plus directed cases with hand-computed results.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk_in = 1'b0;
  logic         rst_in = 1'b0;
  logic         start_in = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         c_in = 1'b0;
  logic         busy_out;
  logic         done_out;
  logic [W-1:0] sum_out;
  logic         c_out;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;
  int cycle = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in),
    .a_in(a_in), .b_in(b_in), .c_in(c_in),
    .busy_out(busy_out), .done_out(done_out),
    .sum_out(sum_out), .c_out(c_out)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cycle <= cycle + 1;

  // Reference model: remaining run cycles, a done flag and the full-width sum.
  int         m_run_left = 0;
  bit         m_done = 1'b0;
  logic [W:0] m_pend = '0;
  logic [W-1:0] m_sum = '0;
  logic       m_cout = 1'b0;

  always @(posedge clk_in) begin
    if (rst_in) begin
      m_run_left <= 0;
      m_done     <= 1'b0;
      m_sum      <= '0;
      m_cout     <= 1'b0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_run_left > 0) begin
      m_run_left <= m_run_left - 1;
      if (m_run_left == 1) begin
        m_done <= 1'b1;
        m_sum  <= m_pend[W-1:0];
        m_cout <= m_pend[W];
      end
    end else if (start_in) begin
      m_run_left <= W;
      m_pend     <= {1'b0, a_in} + {1'b0, b_in} + {{W{1'b0}}, c_in};
    end
  end

  always @(negedge clk_in) begin
    if (check_en) begin
      checks += 4;
      if (busy_out !== (m_run_left > 0)) begin
        errors++;
        $display("[TB] FAIL busy_out cycle %0d got %b expected %b", cycle, busy_out, m_run_left > 0);
      end
      if (done_out !== m_done) begin
        errors++;
        $display("[TB] FAIL done_out cycle %0d got %b expected %b", cycle, done_out, m_done);
      end
      if (sum_out !== m_sum) begin
        errors++;
        $display("[TB] FAIL sum_out cycle %0d got %h expected %h", cycle, sum_out, m_sum);
      end
      if (c_out !== m_cout) begin
        errors++;
        $display("[TB] FAIL c_out cycle %0d got %b expected %b", cycle, c_out, m_cout);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [W-1:0] exp_sum, input logic exp_c);
    checks += 2;
    if (sum_out !== exp_sum) begin
      errors++;
      $display("[TB] FAIL %s sum got %h expected %h", name, sum_out, exp_sum);
    end
    if (c_out !== exp_c) begin
      errors++;
      $display("[TB] FAIL %s carry got %b expected %b", name, c_out, exp_c);
    end
  endtask

  task automatic checkValue(input string name, input int got, input int expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("[TB] FAIL %s got %0d expected %0d", name, got, expv);
    end
  endtask

  // Returns the number of negedges waited until done_out is seen, or -1 on timeout.
  task automatic waitDone(output int n);
    n = -1;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk_in);
      if (done_out === 1'b1) begin
        n = i;
        break;
      end
    end
    if (n < 0) begin
      errors++;
      $display("[TB] FAIL done timeout got no pulse expected one within 60 cycles");
    end
  endtask

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                               output int lat);
    a_in = a; b_in = b; c_in = cin; start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    a_in = $urandom; b_in = $urandom; c_in = $urandom_range(0, 1);
    waitDone(lat);
  endtask

  initial begin
    int lat;
    int t1;
    int t2;

    @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    check_en = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    repeat (10) @(negedge clk_in);
    checkOutput("reset_idle", 8'h00, 1'b0);

    applyStimulus(8'h3C, 8'h42, 1'b0, lat);
    checkOutput("basic_add", 8'h7E, 1'b0);
    checkValue("basic_latency", lat, W);
    @(negedge clk_in);

    applyStimulus(8'hFF, 8'h01, 1'b0, lat);
    checkOutput("overflow_ff_01", 8'h00, 1'b1);
    @(negedge clk_in);
    applyStimulus(8'hA5, 8'h5A, 1'b1, lat);
    checkOutput("overflow_a5_5a", 8'h00, 1'b1);
    @(negedge clk_in);
    applyStimulus(8'hFF, 8'hFF, 1'b1, lat);
    checkOutput("overflow_ff_ff", 8'hFF, 1'b1);
    @(negedge clk_in);

    // Start while busy: a second request during RUN must be dropped.
    a_in = 8'h01; b_in = 8'h01; c_in = 1'b0; start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    repeat (2) @(negedge clk_in);
    a_in = 8'h10; start_in = 1'b1;
    repeat (3) @(negedge clk_in);
    start_in = 1'b0;
    waitDone(lat);
    checkOutput("start_while_busy", 8'h02, 1'b0);
    repeat (12) @(negedge clk_in);
    checkOutput("start_while_busy_hold", 8'h02, 1'b0);

    // Back-to-back with start held high.
    a_in = 8'h0F; b_in = 8'h01; c_in = 1'b0; start_in = 1'b1;
    waitDone(lat);
    t1 = cycle;
    checkOutput("b2b_first", 8'h10, 1'b0);
    a_in = 8'h20; b_in = 8'h02;
    @(negedge clk_in);
    @(negedge clk_in);
    checkOutput("b2b_hold", 8'h10, 1'b0);
    waitDone(lat);
    t2 = cycle;
    start_in = 1'b0;
    checkOutput("b2b_second", 8'h22, 1'b0);
    checkValue("b2b_spacing", t2 - t1, W + 2);
    repeat (3) @(negedge clk_in);

    // Reset mid-operation aborts without a done pulse.
    a_in = 8'h80; b_in = 8'h80; c_in = 1'b0; start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    repeat (3) @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    checkOutput("reset_mid_op", 8'h00, 1'b0);
    checkValue("reset_mid_busy", int'(busy_out), 0);
    repeat (12) @(negedge clk_in);
    applyStimulus(8'h01, 8'h02, 1'b1, lat);
    checkOutput("after_reset", 8'h04, 1'b0);
    @(negedge clk_in);

    // Random traffic: sporadic starts, free-running operands, rare resets.
    for (int i = 0; i < 3000; i++) begin
      start_in = ($urandom_range(0, 2) == 0);
      a_in     = $urandom;
      b_in     = $urandom;
      c_in     = $urandom_range(0, 1);
      rst_in   = ($urandom_range(0, 149) == 0);
      @(negedge clk_in);
    end
    rst_in = 1'b0;
    start_in = 1'b0;
    repeat (W + 4) @(negedge clk_in);
    check_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial, multi-cycle adder that computes A + B + Cin for WIDTH-bit operands using a single full-adder cell. A carry flip-flop closes the loop around the cell, and one bit is processed per clock, LSB first. The block sits directly upstream of result consumers that need a registered sum. It replaces a WIDTH-wide ripple chain where area matters more than latency. A start/done handshake frames each operation.

## Interface
- WIDTH, 8, operand and sum width in bits; legal range 1..32.

- clk_in  input  1  clock; all state updates on the rising edge.
- rst_in  input  1  synchronous, active-high reset.
- start_in  input  1  request a new addition; sampled only in IDLE.
- a_in  input  WIDTH  operand A; captured on the accepting edge.
- b_in  input  WIDTH  operand B; captured on the accepting edge.
- c_in  input  1  carry-in; captured on the accepting edge.
- busy_out  output  1  high while an operation is in progress (state RUN).
- done_out  output  1  single-cycle pulse; sum_out and c_out are valid and newly updated.
- sum_out  output  WIDTH  registered sum, WIDTH LSBs of A+B+Cin.
- c_out  output  1  registered carry-out (bit WIDTH of A+B+Cin).

## Operation
- State machine with three states:
  - IDLE: waits for start_in.
  - RUN: processes one bit per cycle.
  - DONE: one cycle; asserts done_out.
- Internal registers:
  - opa and opb: WIDTH-bit shift registers.
  - carry: 1 bit.
  - acc: WIDTH-bit sum shift register.
  - cnt: ceil(log2(WIDTH+1)) bits.
- IDLE, start_in=1 at an edge:
  - opa<=a_in, opb<=b_in, carry<=c_in, acc<=0, cnt<=0.
  - State -> RUN.
- IDLE, start_in=0: hold all state.
- RUN, each edge:
  - s = opa[0]^opb[0]^carry.
  - carry <= majority(opa[0], opb[0], carry).
  - acc <= {s, acc[WIDTH-1:1]}.
  - opa and opb shift right by 1, filling with 0.
  - cnt <= cnt+1.
- RUN, edge where cnt == WIDTH-1 (the final bit):
  - Additionally sum_out <= {s, acc[WIDTH-1:1]} and c_out <= new carry.
  - State -> DONE.
- DONE: done_out=1; state -> IDLE on the next edge unconditionally.
- start_in is ignored in RUN and in DONE. It is not queued; the requester must re-assert it in IDLE.
- sum_out and c_out change only on the final RUN edge. They hold their value through IDLE and through subsequent RUN cycles until the next completion.
- Arithmetic is unsigned modulo 2^WIDTH. Overflow is reported only via c_out; no saturation.
- WIDTH=1: RUN lasts exactly one cycle. Behaviour is otherwise identical.

## Timing
- Reset (rst_in=1 at an edge) has priority over everything:
  - State -> IDLE.
  - busy_out=0, done_out=0, sum_out=0, c_out=0.
  - opa, opb, acc, carry and cnt all cleared.
- Reset during RUN or DONE aborts the operation; no done_out pulse follows.
- Start accepted at edge T:
  - busy_out=1 from T through T+WIDTH-1.
  - Final bit computed at edge T+WIDTH; done_out=1 in the cycle after edge T+WIDTH, for exactly 1 cycle.
- Latency from the accepting edge to done_out assertion: WIDTH cycles.
- Throughput: one operation per WIDTH+2 cycles. The earliest next accepting edge is T+WIDTH+2, with start_in held through the DONE cycle.
- busy_out and done_out are never high simultaneously.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Inputs a_in, b_in and c_in may change freely after the accepting edge.

## Test plan
- Reset then idle: rst_in=1 for 2 cycles, start_in=0 for 10 cycles -> busy_out=0, done_out=0, sum_out=0x00, c_out=0 throughout.
- Basic add, WIDTH=8:
  - Stimulus: A=0x3C, B=0x42, Cin=0; start for 1 cycle.
  - Response: busy_out high 8 cycles; done_out pulses 8 cycles after the accepting edge; sum_out=0x7E, c_out=0.
- Carry propagation and overflow:
  - A=0xFF, B=0x01, Cin=0 -> sum_out=0x00, c_out=1.
  - A=0xA5, B=0x5A, Cin=1 -> sum_out=0x00, c_out=1.
  - A=0xFF, B=0xFF, Cin=1 -> sum_out=0xFF, c_out=1.
- Start while busy:
  - Stimulus: start A=0x01, B=0x01; assert start_in again with A=0x10 on cycles 3..5 of RUN.
  - Response: single done_out; sum_out=0x02; the second request is dropped.
- Back-to-back:
  - Stimulus: hold start_in=1 continuously with A=0x0F, B=0x01, then change to A=0x20, B=0x02 after the first done_out.
  - Response: done_out pulses 10 cycles apart; results are 0x10 then 0x22; sum_out holds 0x10 in between.
- Reset mid-operation:
  - Stimulus: start A=0x80, B=0x80; assert rst_in at RUN cycle 4.
  - Response: no done_out pulse; outputs return to 0.
  - Follow-up: next start with A=0x01, B=0x02, Cin=1 -> sum_out=0x04, c_out=0.
